// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Pipeline sequencing controller for the 5-stage core.
//                Generates per-stage stall vector, holds the pipe for
//                multi-cycle EX operations and flushes/redirects on
//                exception or eret.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int          CNT_W      = 6,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter logic [31:0] ERET_CODE  = 32'h0000_000e
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             ex_mc_start,
    input  logic [CNT_W-1:0] ex_mc_len,
    input  logic [31:0]      excepttype_i,
    input  logic [31:0]      epc_i,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             mc_busy,
    output logic             mc_done
);

    // FSM encoding
    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_mc_run = 1'b1;

    // Stall patterns: EX-level stall holds PC..EX, ID-level holds PC..ID
    localparam logic [5:0] c_stall_none = 6'b000000;
    localparam logic [5:0] c_stall_id   = 6'b000111;
    localparam logic [5:0] c_stall_ex   = 6'b001111;

    localparam logic [CNT_W-1:0] c_cnt_zero = '0;
    localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       r_state_q;
    logic [0:0]       w_state_d;
    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;

    // Next-state and output decode; priority rst > exception > MC_RUN > EX > ID
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        stall     = c_stall_none;
        flush     = 1'b0;
        new_pc    = 32'h0;
        mc_busy   = 1'b0;
        mc_done   = 1'b0;

        if (rst) begin
            // Outputs forced low; state reset happens in the sequential block
            w_state_d = c_st_idle;
            w_cnt_d   = c_cnt_zero;
        end else if (excepttype_i != 32'h0) begin
            // Flush everything; any in-flight multi-cycle op is dropped silently
            flush     = 1'b1;
            new_pc    = (excepttype_i == ERET_CODE) ? epc_i : EXC_VECTOR;
            mc_busy   = (r_state_q == c_st_mc_run);
            w_state_d = c_st_idle;
            w_cnt_d   = c_cnt_zero;
        end else if (r_state_q == c_st_mc_run) begin
            mc_busy = 1'b1;
            if (r_cnt_q > c_cnt_one) begin
                stall   = c_stall_ex;
                w_cnt_d = r_cnt_q - c_cnt_one;
            end else begin
                // Final cycle: release the pipe so EX/MEM captures the result
                mc_done   = 1'b1;
                w_state_d = c_st_idle;
            end
        end else begin
            if (ex_mc_start) begin
                // Start cycle itself is a stall; a zero length counts as one
                stall     = c_stall_ex;
                w_state_d = c_st_mc_run;
                w_cnt_d   = (ex_mc_len == c_cnt_zero) ? c_cnt_one : ex_mc_len;
            end else if (stallreq_ex) begin
                stall = c_stall_ex;
            end else if (stallreq_id) begin
                stall = c_stall_id;
            end
        end
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= c_st_idle;
            r_cnt_q   <= c_cnt_zero;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Directed self-checking bench for pipe_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int CNT_W = 6;

    logic             clk;
    logic             rst;
    logic             stallreq_id;
    logic             stallreq_ex;
    logic             ex_mc_start;
    logic [CNT_W-1:0] ex_mc_len;
    logic [31:0]      excepttype_i;
    logic [31:0]      epc_i;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             mc_busy;
    logic             mc_done;

    int checks;
    int failures;

    pipe_ctrl #(
        .CNT_W      (CNT_W),
        .EXC_VECTOR (32'h0000_0020),
        .ERET_CODE  (32'h0000_000e)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_len    (ex_mc_len),
        .excepttype_i (excepttype_i),
        .epc_i        (epc_i),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .mc_busy      (mc_busy),
        .mc_done      (mc_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare all outputs for the current cycle (inputs already settled)
    task automatic chk_all(input string tag, input logic [5:0] e_stall, input logic e_flush,
                           input logic [31:0] e_pc, input logic e_busy, input logic e_done);
        #1;
        chk({tag, ".stall"},   {26'h0, stall},   {26'h0, e_stall});
        chk({tag, ".flush"},   {31'h0, flush},   {31'h0, e_flush});
        chk({tag, ".new_pc"},  new_pc,           e_pc);
        chk({tag, ".mc_busy"}, {31'h0, mc_busy}, {31'h0, e_busy});
        chk({tag, ".mc_done"}, {31'h0, mc_done}, {31'h0, e_done});
    endtask

    // Advance one clock; inputs change 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stallreq_id  = 1'b0;
        stallreq_ex  = 1'b0;
        ex_mc_start  = 1'b0;
        ex_mc_len    = '0;
        excepttype_i = 32'h0;
        epc_i        = 32'h0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // ---- 1: reset with every input active -> all outputs zero
        rst          = 1'b1;
        stallreq_id  = 1'b1;
        stallreq_ex  = 1'b1;
        ex_mc_start  = 1'b1;
        ex_mc_len    = 6'd5;
        excepttype_i = 32'h1;
        epc_i        = 32'h0000_1234;
        chk_all("rst_active", 6'h00, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        chk_all("rst_held", 6'h00, 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        idle_inputs();
        chk_all("post_rst", 6'h00, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();

        // ---- 2: simple stall requests, no state change
        stallreq_id = 1'b1;
        chk_all("stall_id", 6'h07, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        stallreq_ex = 1'b1;
        chk_all("stall_id_ex", 6'h0f, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        idle_inputs();
        stallreq_ex = 1'b1;
        chk_all("stall_ex", 6'h0f, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        idle_inputs();
        chk_all("stall_release", 6'h00, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();

        // ---- 3: multi-cycle op of length 4
        ex_mc_start = 1'b1;
        ex_mc_len   = 6'd4;
        chk_all("mc4_t0", 6'h0f, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        // start and stall requests are ignored while running; len ignored after start
        ex_mc_start = 1'b1;
        ex_mc_len   = 6'd9;
        stallreq_id = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            chk_all($sformatf("mc4_t%0d", i), 6'h0f, 1'b0, 32'h0, 1'b1, 1'b0);
            tick();
        end
        chk_all("mc4_t4", 6'h00, 1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        idle_inputs();
        chk_all("mc4_idle", 6'h00, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();

        // ---- 4: lengths 0 and 1 behave identically
        for (int len = 0; len <= 1; len++) begin
            ex_mc_start = 1'b1;
            ex_mc_len   = CNT_W'(len);
            chk_all($sformatf("mclen%0d_t0", len), 6'h0f, 1'b0, 32'h0, 1'b0, 1'b0);
            tick();
            idle_inputs();
            chk_all($sformatf("mclen%0d_t1", len), 6'h00, 1'b0, 32'h0, 1'b1, 1'b1);
            tick();
            chk_all($sformatf("mclen%0d_t2", len), 6'h00, 1'b0, 32'h0, 1'b0, 1'b0);
            tick();
        end

        // ---- 5: exception during MC_RUN cycle 2 of a length-8 op
        ex_mc_start = 1'b1;
        ex_mc_len   = 6'd8;
        chk_all("mc8_t0", 6'h0f, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        idle_inputs();
        chk_all("mc8_t1", 6'h0f, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        excepttype_i = 32'h1;
        epc_i        = 32'h0000_5555;
        chk_all("mc8_exc", 6'h00, 1'b1, 32'h0000_0020, 1'b1, 1'b0);
        tick();
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            chk_all($sformatf("mc8_after%0d", i), 6'h00, 1'b0, 32'h0, 1'b0, 1'b0);
            tick();
        end

        // ---- 6: eret overrides an EX stall and redirects to epc
        excepttype_i = 32'h0000_000e;
        epc_i        = 32'h0000_1234;
        stallreq_ex  = 1'b1;
        chk_all("eret", 6'h00, 1'b1, 32'h0000_1234, 1'b0, 1'b0);
        tick();
        idle_inputs();

        // exception in IDLE suppresses a simultaneous multi-cycle start
        excepttype_i = 32'h0000_0004;
        ex_mc_start  = 1'b1;
        ex_mc_len    = 6'd3;
        chk_all("exc_start", 6'h00, 1'b1, 32'h0000_0020, 1'b0, 1'b0);
        tick();
        idle_inputs();
        chk_all("exc_start_next", 6'h00, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();

        // ---- reset in the middle of an operation aborts it without mc_done
        ex_mc_start = 1'b1;
        ex_mc_len   = 6'd5;
        tick();
        idle_inputs();
        chk_all("mc5_t1", 6'h0f, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        chk_all("mc5_rst", 6'h00, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_all($sformatf("mc5_after%0d", i), 6'h00, 1'b0, 32'h0, 1'b0, 1'b0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
